// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch squash and data-memory wait/timeout.
// Optional perf counters are built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ack,
  output logic             dmem_valid,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic             stall,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WCNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  // With no timeout the wait counter just parks at all-ones.
  localparam logic [WCNT_W-1:0] WCNT_SAT = (TIMEOUT_CYC == 0) ? {WCNT_W{1'b1}} : WCNT_W'(TIMEOUT_CYC);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              mem_err_q, mem_err_d;

  logic hold, abort, timeout_hit, load_use_hit;
  logic valid_c, pc_c, ifid_c, ifidf_c, idex_c, idexf_c, exm_c, mwbf_c;

  assign timeout_hit  = (TIMEOUT_CYC != 0) && (wcnt_q == WCNT_SAT);
  assign load_use_hit = ex_mem_read && (ex_rd != 5'd0) &&
                        ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_err_d = 1'b0;
    valid_c   = 1'b0;
    hold      = 1'b0;
    abort     = 1'b0;
    pc_c      = 1'b1;
    ifid_c    = 1'b1;
    ifidf_c   = 1'b0;
    idex_c    = 1'b1;
    idexf_c   = 1'b0;
    exm_c     = 1'b1;
    mwbf_c    = 1'b0;
    case (state_q)
      ST_RUN: begin
        valid_c = mem_req;
        if (mem_req && !dmem_ack) begin
          hold    = 1'b1;
          state_d = ST_WAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      ST_WAIT: begin
        valid_c = 1'b1;
        if (dmem_ack) begin
          state_d = ST_RUN;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          valid_c   = 1'b0;
          mem_err_d = 1'b1;
          state_d   = ST_RUN;
          wcnt_d    = '0;
        end else begin
          hold = 1'b1;
          if (wcnt_q != WCNT_SAT) wcnt_d = wcnt_q + 1'b1;
        end
      end
    endcase
    // A held MEM stage freezes everything upstream, so branch and load-use wait for release.
    if (hold) begin
      pc_c   = 1'b0;
      ifid_c = 1'b0;
      idex_c = 1'b0;
      exm_c  = 1'b0;
      mwbf_c = 1'b1;
    end else begin
      if (abort) mwbf_c = 1'b1;
      if (branch_taken) begin
        ifidf_c = 1'b1;
        idexf_c = 1'b1;
      end else if (load_use_hit) begin
        pc_c    = 1'b0;
        ifid_c  = 1'b0;
        idexf_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign dmem_valid   = rst_n & valid_c;
  assign pc_en        = rst_n & pc_c;
  assign if_id_en     = rst_n & ifid_c;
  assign if_id_flush  = rst_n & ifidf_c;
  assign id_ex_en     = rst_n & idex_c;
  assign id_ex_flush  = rst_n & idexf_c;
  assign ex_mem_en    = rst_n & exm_c;
  assign mem_wb_flush = rst_n & mwbf_c;
  assign stall        = rst_n & ~(pc_c & ifid_c & idex_c & exm_c);
  assign mem_err      = mem_err_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, stall};
      flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, (if_id_flush | id_ex_flush)};
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl against a cycle-level reference model.
// Counter expectations follow HAZ_PERF_CNT_EN the same way the design does.
module tb_pipeline_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 32;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic [4:0]    id_rs = '0, id_rt = '0, ex_rd = '0;
  logic          id_uses_rt = 1'b0, ex_mem_read = 1'b0, branch_taken = 1'b0;
  logic          mem_req = 1'b0, dmem_ack = 1'b0;
  logic          dmem_valid, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic          ex_mem_en, mem_wb_flush, stall, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .mem_req(mem_req), .dmem_ack(dmem_ack), .dmem_valid(dmem_valid),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_flush(mem_wb_flush), .stall(stall), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic [9:0]    bits;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: in a memory wait, how many wait cycles so far, pending error pulse, counters.
  bit            m_wait = 0;
  int            m_cnt  = 0;
  bit            m_err  = 0;
  logic [CW-1:0] m_sc   = '0;
  logic [CW-1:0] m_fc   = '0;

  initial begin
    exp_t e;
    bit   rst, hold, abort, lu, vld, pc, ifid, ifidf, idex, idexf, exm, mwbf, stl;
    int   rst_left;
    rst_left = 3;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (rst_left == 0 && m_wait && ($urandom % 40) == 0) rst_left = 2;
      rst = (rst_left == 0);
      if (rst_left > 0) rst_left--;
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      id_uses_rt   = 1'($urandom % 2);
      ex_mem_read  = (($urandom % 3) == 0);
      branch_taken = (($urandom % 5) == 0);
      mem_req      = (($urandom % 5) < 2);
      dmem_ack     = (($urandom % 4) == 0);
      rst_n        = rst;

      if (!rst) begin
        e = '0;
        m_wait = 0; m_cnt = 0; m_err = 0; m_sc = '0; m_fc = '0;
      end else begin
        hold = 0; abort = 0;
        if (!m_wait) begin
          vld  = mem_req;
          hold = mem_req && !dmem_ack;
        end else begin
          vld = 1;
          if (!dmem_ack && m_cnt == TO) begin
            abort = 1;
            vld   = 0;
          end else if (!dmem_ack) begin
            hold = 1;
          end
        end
        lu = ex_mem_read && ex_rd != 0 &&
             (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
        pc = 1; ifid = 1; ifidf = 0; idex = 1; idexf = 0; exm = 1; mwbf = abort;
        if (hold) begin
          pc = 0; ifid = 0; idex = 0; exm = 0; mwbf = 1;
        end else if (branch_taken) begin
          ifidf = 1; idexf = 1;
        end else if (lu) begin
          pc = 0; ifid = 0; idexf = 1;
        end
        stl    = !(pc && ifid && idex && exm);
        e.bits = {vld, pc, ifid, ifidf, idex, idexf, exm, mwbf, stl, m_err};
        e.sc   = m_sc;
        e.fc   = m_fc;
`ifdef HAZ_PERF_CNT_EN
        m_sc = m_sc + CW'(stl);
        m_fc = m_fc + CW'(ifidf | idexf);
`endif
        if (m_wait && !hold)
          $display("mem access done at %0t: %0d wait cycles, %s", $time, m_cnt,
                   abort ? "timed out" : "acked");
        m_err = abort;
        if (hold) begin
          m_cnt  = m_wait ? m_cnt + 1 : 1;
          m_wait = 1;
        end else begin
          m_wait = 0;
        end
      end
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  exp_t       mon_e;
  logic [9:0] mon_act;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e   = q.pop_front();
      mon_act = {dmem_valid, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                 ex_mem_en, mem_wb_flush, stall, mem_err};
      n_vec++;
      if (mon_act !== mon_e.bits) begin
        n_err++;
        $display("FAIL ctrl t=%0t {valid,pc,ifid,ifidf,idex,idexf,exm,mwbf,stall,err} got %b want %b",
                 $time, mon_act, mon_e.bits);
      end
      if (stall_cnt !== mon_e.sc) begin
        n_err++;
        $display("FAIL stall_cnt t=%0t got %0d want %0d", $time, stall_cnt, mon_e.sc);
      end
      if (flush_cnt !== mon_e.fc) begin
        n_err++;
        $display("FAIL flush_cnt t=%0t got %0d want %0d", $time, flush_cnt, mon_e.fc);
      end
    end
  end

endmodule
